// File: rtl/fifo_sync_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses, synchronous flush and optional FWFT read.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Request semantics: wr_en/rd_en are requests sampled on the rising edge.
  // A request is accepted only when the flag it depends on (full for writes,
  // empty for reads) is low before that edge; a rejected request is dropped and
  // reported by a one-cycle overflow/underflow pulse. clear overrides both.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Flags decode the registered count, so they follow the causing edge by a cycle.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Storage is deliberately not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_acc && !clear && !rst) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_out <= '0;
        else if (clear)  data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags: a standard-read and an FWFT instance share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_fifo_sync_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic             f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0]    s_count, f_count;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_udf;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string step);
    int n;
    logic [WIDTH-1:0] head;
    n = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    chk({step, ":std_count"}, 32'(s_count), 32'(n));
    chk({step, ":std_empty"}, 32'(s_empty), 32'(n == 0));
    chk({step, ":std_full"},  32'(s_full),  32'(n == DEPTH));
    chk({step, ":std_af"},    32'(s_af),    32'(n >= AF));
    chk({step, ":std_ae"},    32'(s_ae),    32'(n <= AE));
    chk({step, ":std_ovf"},   32'(s_ovf),   32'(m_ovf));
    chk({step, ":std_udf"},   32'(s_udf),   32'(m_udf));
    chk({step, ":std_dout"},  32'(s_dout),  32'(m_dout));
    chk({step, ":fw_count"},  32'(f_count), 32'(n));
    chk({step, ":fw_empty"},  32'(f_empty), 32'(n == 0));
    chk({step, ":fw_full"},   32'(f_full),  32'(n == DEPTH));
    chk({step, ":fw_af"},     32'(f_af),    32'(n >= AF));
    chk({step, ":fw_ae"},     32'(f_ae),    32'(n <= AE));
    chk({step, ":fw_ovf"},    32'(f_ovf),   32'(m_ovf));
    chk({step, ":fw_udf"},    32'(f_udf),   32'(m_udf));
    chk({step, ":fw_dout"},   32'(f_dout),  32'(head));
  endtask

  // One clock cycle: drive requests, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input logic wr, input logic [WIDTH-1:0] din,
                      input logic rd, input logic clr);
    int n;
    wr_en = wr; data_in = din; rd_en = rd; clear = clr;
    @(posedge clk);
    n = exp_q.size();
    if (clr) begin
      exp_q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    end else begin
      m_ovf = wr && (n == DEPTH);
      m_udf = rd && (n == 0);
      if (rd && n > 0) m_dout = exp_q.pop_front();
      if (wr && n < DEPTH) exp_q.push_back(din);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    check_all({tag, ":async"});
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ":held"});
    rst = 1'b0;
  endtask

  initial begin
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0;
    @(posedge clk); #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then registered reads
    step("w11", 1, 8'h11, 0, 0);
    step("w22", 1, 8'h22, 0, 0);
    step("w33", 1, 8'h33, 0, 0);
    step("w44", 1, 8'h44, 0, 0);
    step("w55", 1, 8'h55, 0, 0);
    for (int i = 0; i < 3; i++) step("rd3", 0, 8'h00, 1, 0);
    step("idle", 0, 8'h00, 0, 0);
    step("drain_a", 0, 8'h00, 1, 0);
    step("drain_b", 0, 8'h00, 1, 0);

    // Fill to full, overflow, drain
    for (int i = 0; i < 16; i++) step("fill", 1, 8'(i), 0, 0);
    step("ovf_ff", 1, 8'hFF, 0, 0);
    step("ovf_gone", 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1, 0);

    // Underflow on empty, then simultaneous wr+rd on empty
    step("udf", 0, 8'h00, 1, 0);
    step("udf_gone", 0, 8'h00, 0, 0);
    step("wr_rd_empty", 1, 8'hA5, 1, 0);

    // Simultaneous wr+rd on full
    for (int i = 0; i < 15; i++) step("fill2", 1, 8'($urandom_range(0, 255)), 0, 0);
    step("wr_rd_full", 1, 8'h77, 1, 0);
    for (int i = 0; i < 15; i++) step("drain2", 0, 8'h00, 1, 0);

    // Pointer wrap with constant occupancy, then clear with write
    for (int i = 0; i < 8; i++) step("fill8", 1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 20; i++) step("wrap", 1, 8'($urandom_range(0, 255)), 1, 0);
    step("clear_wr", 1, 8'hEE, 1, 1);
    step("after_clear", 0, 8'h00, 0, 0);

    // FWFT head visibility
    step("w3c", 1, 8'h3C, 0, 0);
    step("fw_hold", 0, 8'h00, 0, 0);
    step("w4d", 1, 8'h4D, 0, 0);
    step("pop3c", 0, 8'h00, 1, 0);
    step("pop4d", 0, 8'h00, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end
    for (int i = 0; i < 200; i++) begin
      step("rand_wr_heavy", ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset in the middle of a write burst
    for (int i = 0; i < 6; i++) step("burst", 1, 8'($urandom_range(0, 255)), 0, 0);
    wr_en = 1'b1; data_in = 8'h99;
    do_reset("rst_mid");
    step("post_rst_w", 1, 8'h5A, 0, 0);
    step("post_rst_r", 0, 8'h00, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised synchronous FIFO for the UART TX/RX data paths; successor to the basic dual-port FIFO.
- Adds generic width and depth, occupancy count, programmable almost-full/almost-empty thresholds, sticky-free overflow/underflow error pulses, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the UART byte engines and the host-side register interface.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush, active-high
wr_en  input  1  write request
data_in  input  WIDTH  write data
rd_en  input  1  read request
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr, count = 0; data_out = 0; overflow = underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all data immediately.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no bubble. Count is held in its own register.
- Write is accepted iff wr_en && !full; mem[wr_ptr] <= data_in, then wr_ptr++.
- Read is accepted iff rd_en && !empty; rd_ptr++.
- Accept decisions use the flags as they stand before the edge:
  - Read+write when empty: write accepted, read rejected (underflow), count 0->1.
  - Read+write when full: read accepted, write rejected (overflow), count DEPTH->DEPTH-1.
  - Both accepted otherwise: count unchanged.
- Flags are combinational decodes of the registered count, so they change in the cycle after the causing edge.
- overflow/underflow are registered. Each is high for exactly one cycle after an edge where the corresponding request was rejected, and stays high on consecutive cycles if rejection repeats.
- clear=1 (synchronous):
  - Pointers and count go to 0; overflow/underflow go to 0; data_out goes to 0 in standard mode.
  - clear has priority: wr_en/rd_en in the same cycle are ignored and raise no error pulses.
- FWFT=0:
  - data_out is registered; on the edge of an accepted read, data_out <= mem[rd_ptr]. Data is valid 1 cycle after rd_en.
  - data_out holds its value otherwise, including on rejected reads.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally while !empty, else 0. The head word is visible before rd_en; rd_en pops it.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- No combinational path from data_in to data_out in either mode.

Test Plan:
1. Reset, FWFT=0, DEPTH=16: write 11,22,33,44,55 then assert rd_en for 3 cycles -> data_out 11,22,33 each one cycle after its rd_en edge; count 5->2; almost_empty=1 at count 2.
2. Write 0x00..0x0F (16 words) -> almost_full rises when count reaches 12, full rises at count 16. Extra write of FF -> overflow pulses 1 cycle, count stays 16. Drain 16 reads -> 00..0F in order with no FF, empty=1.
3. Empty FIFO, one more rd_en -> underflow pulses 1 cycle, data_out holds its last value, count stays 0. Simultaneous wr_en(A5)+rd_en on empty -> count 1, underflow=1.
4. Full FIFO, simultaneous wr_en(77)+rd_en -> head word read, overflow=1, count 15, 77 not stored.
5. Fill with 8 words, toggle pointer wrap with 20 interleaved write/read pairs -> data order preserved, count constant at 8. Assert clear together with wr_en -> count 0, empty=1, no overflow. Assert rst mid-burst -> outputs return to reset values immediately.
6. FWFT=1: write 3C into empty FIFO -> data_out=3C the next cycle with no rd_en; rd_en -> data_out shows the next word, or 0 when empty.
